// File: rtl/pad_sync_filter.sv
// -----------------------------------------------------------------------------
// pad_sync_filter
//   Input-conditioning stage placed in front of the pad buffer cells.
//   The asynchronous pad input A is brought into the CLK domain through a
//   SYNC_STAGES-deep synchroniser. A new level is accepted onto Z only after it
//   has held for FILTER_CYCLES CE-qualified clocks. One-cycle RISE/FALL strobes
//   mark the cycle in which Z takes its new value.
//
// Parameters
//   SYNC_STAGES    synchroniser depth, 2..4
//   FILTER_CYCLES  CE-qualified cycles a new level must hold, 1..65535
//   RESET_VAL      reset value of the synchroniser flops and of Z
//
// Ports
//   CLK         in   clock, rising edge
//   RST         in   asynchronous active-high reset
//   CE          in   filter clock enable (the synchroniser ignores it)
//   A           in   asynchronous raw pad input
//   Z           out  filtered level
//   RISE        out  one-cycle pulse when Z becomes 1
//   FALL        out  one-cycle pulse when Z becomes 0
//   BUSY        out  a candidate level is being qualified
//   CLR_GLITCH  in   (optional) synchronous clear of GLITCH_CNT
//   GLITCH_CNT  out  (optional) saturating count of rejected candidates
//
// Optional feature macro: PAD_SYNC_FILTER_GLITCH_CNT_EN
//   When defined, adds CLR_GLITCH / GLITCH_CNT and the rejected-glitch counter.
//   Z/RISE/FALL/BUSY timing is the same in both builds.
// -----------------------------------------------------------------------------
module pad_sync_filter #(
  parameter int   SYNC_STAGES   = 2,
  parameter int   FILTER_CYCLES = 4,
  parameter logic RESET_VAL     = 1'b0
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       CE,
  input  logic       A,
`ifdef PAD_SYNC_FILTER_GLITCH_CNT_EN
  input  logic       CLR_GLITCH,
  output logic [7:0] GLITCH_CNT,
`endif
  output logic       Z,
  output logic       RISE,
  output logic       FALL,
  output logic       BUSY
);

  // Counter only ever reaches FILTER_CYCLES-1, so this width never wraps.
  localparam int CW = $clog2(FILTER_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(FILTER_CYCLES - 1);

  typedef enum logic {
    STABLE  = 1'b0,
    QUALIFY = 1'b1
  } state_e;

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic [CW-1:0]          cnt_q, cnt_d;
  state_e                 state_q, state_d;
  logic                   z_q, z_d;
  logic                   rise_q, rise_d;
  logic                   fall_q, fall_d;
  logic                   s;

  // Synchronised sample is the oldest stage of the shift chain.
  assign s = sync_q[SYNC_STAGES-1];

  // Synchroniser shift: runs every clock, independent of CE.
  always_comb begin
    sync_d = {sync_q[SYNC_STAGES-2:0], A};
  end

  // Filter next-state: hold/reject, accept, or keep counting.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    z_d     = z_q;
    rise_d  = 1'b0;
    fall_d  = 1'b0;
    if (CE) begin
      if (s == z_q) begin
        // Level matches output again: any candidate is silently abandoned.
        cnt_d   = {CW{1'b0}};
        state_d = STABLE;
      end else if (cnt_q == CNT_LAST) begin
        // Candidate has held long enough; with FILTER_CYCLES=1 this fires at cnt 0.
        z_d     = s;
        cnt_d   = {CW{1'b0}};
        state_d = STABLE;
        rise_d  = s;
        fall_d  = ~s;
      end else begin
        cnt_d   = cnt_q + {{(CW-1){1'b0}}, 1'b1};
        state_d = QUALIFY;
      end
    end else begin
      // Frozen while CE is low; strobes are forced off by the defaults.
      cnt_d   = cnt_q;
      state_d = state_q;
    end
  end

  // State registers with asynchronous reset.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      sync_q  <= {SYNC_STAGES{RESET_VAL}};
      cnt_q   <= {CW{1'b0}};
      state_q <= STABLE;
      z_q     <= RESET_VAL;
      rise_q  <= 1'b0;
      fall_q  <= 1'b0;
    end else begin
      sync_q  <= sync_d;
      cnt_q   <= cnt_d;
      state_q <= state_d;
      z_q     <= z_d;
      rise_q  <= rise_d;
      fall_q  <= fall_d;
    end
  end

  assign Z    = z_q;
  assign RISE = rise_q;
  assign FALL = fall_q;
  // QUALIFY is held exactly when cnt != 0.
  assign BUSY = (state_q == QUALIFY);

`ifdef PAD_SYNC_FILTER_GLITCH_CNT_EN
  logic [7:0] glitch_q, glitch_d;
  logic       reject_s;

  // A rejection is a matching sample arriving while a candidate was counting.
  assign reject_s = CE && (s == z_q) && (cnt_q != {CW{1'b0}});

  // Glitch counter next value: clear wins, then saturating increment.
  always_comb begin
    glitch_d = glitch_q;
    if (CLR_GLITCH) begin
      glitch_d = 8'd0;
    end else if (reject_s && (glitch_q != 8'hFF)) begin
      glitch_d = glitch_q + 8'd1;
    end else begin
      glitch_d = glitch_q;
    end
  end

  // Glitch counter register.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      glitch_q <= 8'd0;
    end else begin
      glitch_q <= glitch_d;
    end
  end

  assign GLITCH_CNT = glitch_q;
`endif

endmodule

// File: tb/tb_pad_sync_filter.sv
// -----------------------------------------------------------------------------
// tb_pad_sync_filter
//   Directed self-checking bench. Main instance uses defaults (2 sync stages,
//   4 filter cycles); a second instance uses FILTER_CYCLES=1. Inputs change 1
//   time unit after a rising edge; outputs are sampled at the same point.
// -----------------------------------------------------------------------------
module tb_pad_sync_filter;

  logic       CLK;
  logic       RST;
  logic       CE;
  logic       A;
  logic       a1;
  logic       clr_glitch;
  logic       z, rise, fall, busy;
  logic       z1, rise1, fall1, busy1;
  logic [7:0] gc, gc1;

  int checks = 0;
  int passes = 0;

  pad_sync_filter #(.SYNC_STAGES(2), .FILTER_CYCLES(4), .RESET_VAL(1'b0)) dut (
    .CLK(CLK), .RST(RST), .CE(CE), .A(A),
`ifdef PAD_SYNC_FILTER_GLITCH_CNT_EN
    .CLR_GLITCH(clr_glitch), .GLITCH_CNT(gc),
`endif
    .Z(z), .RISE(rise), .FALL(fall), .BUSY(busy)
  );

  pad_sync_filter #(.SYNC_STAGES(2), .FILTER_CYCLES(1), .RESET_VAL(1'b0)) dut1 (
    .CLK(CLK), .RST(RST), .CE(CE), .A(a1),
`ifdef PAD_SYNC_FILTER_GLITCH_CNT_EN
    .CLR_GLITCH(clr_glitch), .GLITCH_CNT(gc1),
`endif
    .Z(z1), .RISE(rise1), .FALL(fall1), .BUSY(busy1)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic test_reset();
    logic [3:0] exp;
    RST = 1'b1; CE = 1'b1; A = 1'b1; a1 = 1'b0; clr_glitch = 1'b0;
    #2;
    checks++;
    if ({z, rise, fall, busy} !== 4'b0000)
      $display("FAIL reset_async {Z,RISE,FALL,BUSY} got %b expected 0000", {z, rise, fall, busy});
    else passes++;
    for (int i = 0; i < 3; i++) step();
    checks++;
    if ({z, rise, fall, busy} !== 4'b0000)
      $display("FAIL reset_hold {Z,RISE,FALL,BUSY} got %b expected 0000", {z, rise, fall, busy});
    else passes++;
    RST = 1'b0;
    // A=1 held through reset: Z rises on edge 5, BUSY on edges 2..4.
    for (int k = 0; k < 7; k++) begin
      step();
      exp = {(k >= 5) ? 1'b1 : 1'b0, (k == 5) ? 1'b1 : 1'b0, 1'b0,
             (k >= 2 && k <= 4) ? 1'b1 : 1'b0};
      checks++;
      if ({z, rise, fall, busy} !== exp)
        $display("FAIL reset_rise edge %0d got %b expected %b", k, {z, rise, fall, busy}, exp);
      else passes++;
    end
  endtask

  task automatic test_fall();
    logic [3:0] exp;
    A = 1'b0;
    for (int k = 0; k < 7; k++) begin
      step();
      exp = {(k < 5) ? 1'b1 : 1'b0, 1'b0, (k == 5) ? 1'b1 : 1'b0,
             (k >= 2 && k <= 4) ? 1'b1 : 1'b0};
      checks++;
      if ({z, rise, fall, busy} !== exp)
        $display("FAIL fall edge %0d got %b expected %b", k, {z, rise, fall, busy}, exp);
      else passes++;
    end
  endtask

  task automatic test_glitch();
    logic [3:0] exp;
    A = 1'b1;
    for (int k = 0; k < 8; k++) begin
      step();
      if (k == 2) A = 1'b0;
      exp = {1'b0, 1'b0, 1'b0, (k >= 2 && k <= 4) ? 1'b1 : 1'b0};
      checks++;
      if ({z, rise, fall, busy} !== exp)
        $display("FAIL glitch edge %0d got %b expected %b", k, {z, rise, fall, busy}, exp);
      else passes++;
    end
`ifdef PAD_SYNC_FILTER_GLITCH_CNT_EN
    checks++;
    if (gc !== 8'd1) $display("FAIL glitch_cnt_one got %0d expected 1", gc);
    else passes++;
`endif
  endtask

  task automatic test_ce_freeze();
    logic [3:0] exp;
    A = 1'b1;
    for (int k = 0; k < 4; k++) step();
    checks++;
    if ({z, busy} !== 2'b01 || dut.cnt_q !== 3'd2)
      $display("FAIL ce_pre {Z,BUSY} got %b cnt %0d expected 01 cnt 2", {z, busy}, dut.cnt_q);
    else passes++;
    CE = 1'b0;
    for (int k = 0; k < 10; k++) begin
      step();
      checks++;
      if ({z, rise, fall, busy} !== 4'b0001 || dut.cnt_q !== 3'd2)
        $display("FAIL ce_frozen cycle %0d got %b cnt %0d expected 0001 cnt 2", k,
                 {z, rise, fall, busy}, dut.cnt_q);
      else passes++;
    end
    CE = 1'b1;
    for (int j = 0; j < 3; j++) begin
      step();
      exp = (j == 0) ? 4'b0001 : ((j == 1) ? 4'b1100 : 4'b1000);
      checks++;
      if ({z, rise, fall, busy} !== exp)
        $display("FAIL ce_resume edge %0d got %b expected %b", j, {z, rise, fall, busy}, exp);
      else passes++;
    end
  endtask

  task automatic test_async_reset();
    A = 1'b0;
    for (int k = 0; k < 5; k++) step();
    checks++;
    if ({z, rise, fall, busy} !== 4'b1001 || dut.cnt_q !== 3'd3)
      $display("FAIL arst_pre got %b cnt %0d expected 1001 cnt 3", {z, rise, fall, busy}, dut.cnt_q);
    else passes++;
    #3 RST = 1'b1;
    #1;
    checks++;
    if ({z, rise, fall, busy} !== 4'b0000)
      $display("FAIL arst_immediate got %b expected 0000", {z, rise, fall, busy});
    else passes++;
    step();
    checks++;
    if ({z, rise, fall, busy} !== 4'b0000)
      $display("FAIL arst_edge got %b expected 0000", {z, rise, fall, busy});
    else passes++;
    RST = 1'b0;
    for (int k = 0; k < 6; k++) begin
      step();
      checks++;
      if ({z, rise, fall, busy} !== 4'b0000)
        $display("FAIL arst_after edge %0d got %b expected 0000", k, {z, rise, fall, busy});
      else passes++;
    end
  endtask

`ifdef PAD_SYNC_FILTER_GLITCH_CNT_EN
  task automatic test_glitch_saturate();
    // Each iteration: candidate counts to 2, then is rejected.
    for (int n = 0; n < 300; n++) begin
      A = 1'b1;
      step(); step();
      A = 1'b0;
      step(); step(); step();
    end
    checks++;
    if (gc !== 8'd255) $display("FAIL glitch_sat got %0d expected 255", gc);
    else passes++;
    checks++;
    if (z !== 1'b0) $display("FAIL glitch_sat_z got %b expected 0", z);
    else passes++;
    clr_glitch = 1'b1;
    step();
    clr_glitch = 1'b0;
    checks++;
    if (gc !== 8'd0) $display("FAIL glitch_clr got %0d expected 0", gc);
    else passes++;
  endtask
`endif

  task automatic test_filter1();
    logic [0:23] hist;
    logic        cur, prev, e_z, e_r, e_f;
    CE = 1'b1;
    a1 = 1'b0;
    for (int k = 0; k < 4; k++) step();
    hist = '0;
    for (int k = 0; k < 24; k++) begin
      a1 = (((k >> 1) & 1) == 0) ? 1'b1 : 1'b0;
      hist[k] = a1;
      step();
      // Z after edge k carries A sampled on edge k-2.
      cur  = (k >= 2) ? hist[k-2] : 1'b0;
      prev = (k >= 3) ? hist[k-3] : 1'b0;
      e_z = cur;
      e_r = cur & ~prev;
      e_f = ~cur & prev;
      checks++;
      if ({z1, rise1, fall1, busy1} !== {e_z, e_r, e_f, 1'b0})
        $display("FAIL filter1 edge %0d got %b expected %b", k, {z1, rise1, fall1, busy1},
                 {e_z, e_r, e_f, 1'b0});
      else passes++;
    end
  endtask

  initial begin
    test_reset();
    test_fall();
    test_glitch();
    test_ce_freeze();
    test_async_reset();
`ifdef PAD_SYNC_FILTER_GLITCH_CNT_EN
    test_glitch_saturate();
`endif
    test_filter1();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout got running expected finished");
    $fatal(1, "watchdog");
  end

endmodule
